fft_addr_sequencer: RTL and testbench

- Sequential address generator for an in-place radix-2 DIT FFT over a 2^LOG2N-point sample RAM.
- After a start pulse, walks every stage and every butterfly in that stage.
- For each butterfly, emits the pair of RAM addresses and the twiddle-ROM index on a valid/ready stream.
- Sits between the FFT controller and the sample RAM / twiddle ROM. It replaces the combinational stage-indexed index mapping with a full stage/butterfly walk that has flow control.

---
 rtl/fft_addr_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_fft_addr_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer
// ------------------
// Address generator for an in-place radix-2 DIT FFT over a 2^LOG2N-point
// sample RAM. A start pulse launches a walk over every stage s and every
// butterfly b of that stage. For each butterfly one word is emitted on a
// valid/ready stream: the two RAM addresses and the twiddle-ROM index.
//
// Optional feature (macro FFT_BITREV_LOAD_EN): a LOAD phase runs before the
// butterflies. It emits N words (addr_a = i, addr_b = bit-reverse(i), tw 0,
// stage all-ones) that drive the bit-reversed input load.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begin a transform; sampled only in IDLE
//   out_ready  in   downstream accepts the current word
//   out_valid  out  addr_a/addr_b/tw_idx/stage/last are valid
//   addr_a     out  upper butterfly address
//   addr_b     out  lower butterfly address (addr_a + 2^stage)
//   tw_idx     out  twiddle-ROM index
//   stage      out  current stage (all-ones during LOAD)
//   last       out  final butterfly word of the transform
//   busy       out  high from start acceptance until FIN
//   done       out  one-cycle pulse after the final word is accepted
//
// Stream handshake: a word moves on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, every
// output holds its value and the counters stay where they are.
module fft_addr_sequencer #(
  parameter int LOG2N   = 8,
  parameter int STAGE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [LOG2N-2:0]   tw_idx,
  output logic [STAGE_W-1:0] stage,
  output logic               last,
  output logic               busy,
  output logic               done
);

  localparam int BW = LOG2N - 1;
  localparam logic [BW-1:0]      B_MAX = '1;               // N/2-1
  localparam logic [STAGE_W-1:0] S_MAX = STAGE_W'(LOG2N - 1);

`ifdef FFT_BITREV_LOAD_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIN = 2'd2, ST_LOAD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIN = 2'd2} state_t;
`endif

  state_t             r_state;
  logic [STAGE_W-1:0] r_s;
  logic [BW-1:0]      r_b;
  logic               r_out_valid;
  logic [LOG2N-1:0]   r_addr_a;
  logic [LOG2N-1:0]   r_addr_b;
  logic [BW-1:0]      r_tw;
  logic [STAGE_W-1:0] r_stage;
  logic               r_last;
  logic               r_busy;
  logic               r_done;

  logic               w_xfer;
  logic               w_b_wrap;
  logic               w_s_last;
  logic [BW-1:0]      w_nxt_b;
  logic [STAGE_W-1:0] w_nxt_s;
  logic [BW-1:0]      w_sel_b;
  logic [STAGE_W-1:0] w_sel_s;
  logic [BW-1:0]      w_pos;
  logic [BW-1:0]      w_grp;
  logic [STAGE_W-1:0] w_sh;
  logic [LOG2N-1:0]   w_addr_a;
  logic [LOG2N-1:0]   w_addr_b;
  logic [BW-1:0]      w_tw;
  logic               w_last;

  always_comb begin
    w_xfer   = r_out_valid & out_ready;
    w_b_wrap = (r_b == B_MAX);
    w_s_last = (r_s == S_MAX);
    w_nxt_b  = w_b_wrap ? '0 : r_b + BW'(1);
    w_nxt_s  = w_b_wrap ? r_s + STAGE_W'(1) : r_s;
    // The word being loaded into the output flops: the next butterfly while
    // running, butterfly (0,0) when entering RUN from IDLE or LOAD.
    w_sel_s  = (r_state == ST_RUN) ? w_nxt_s : '0;
    w_sel_b  = (r_state == ST_RUN) ? w_nxt_b : '0;
    // pos = b mod 2^s ; shifting all-ones left by s clears exactly the low s
    // bits, so its inverse is the mask (and it is all-ones at s = LOG2N-1).
    w_pos    = w_sel_b & ~(B_MAX << w_sel_s);
    w_grp    = w_sel_b >> w_sel_s;
    w_addr_a = (({1'b0, w_grp} << 1) << w_sel_s) | {1'b0, w_pos};
    w_addr_b = w_addr_a + (LOG2N'(1) << w_sel_s);
    w_sh     = S_MAX - w_sel_s;
    w_tw     = w_pos << w_sh;
    w_last   = (w_sel_s == S_MAX) && (w_sel_b == B_MAX);
  end

`ifdef FFT_BITREV_LOAD_EN
  localparam logic [LOG2N-1:0] I_MAX = '1;
  logic [LOG2N-1:0] r_i;
  logic [LOG2N-1:0] w_i_nxt;
  logic [LOG2N-1:0] w_i_rev;

  always_comb begin
    w_i_nxt = r_i + LOG2N'(1);
    w_i_rev = '0;
    for (int k = 0; k < LOG2N; k++) begin
      w_i_rev[k] = w_i_nxt[LOG2N-1-k];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_tw        <= '0;
      r_stage     <= '0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef FFT_BITREV_LOAD_EN
      r_i         <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy      <= 1'b1;
            r_out_valid <= 1'b1;
            r_s         <= '0;
            r_b         <= '0;
`ifdef FFT_BITREV_LOAD_EN
            r_state     <= ST_LOAD;
            r_i         <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_tw        <= '0;
            r_stage     <= '1;
            r_last      <= 1'b0;
`else
            r_state     <= ST_RUN;
            r_addr_a    <= w_addr_a;
            r_addr_b    <= w_addr_b;
            r_tw        <= w_tw;
            r_stage     <= w_sel_s;
            r_last      <= w_last;
`endif
          end
        end
`ifdef FFT_BITREV_LOAD_EN
        ST_LOAD: begin
          if (w_xfer) begin
            if (r_i == I_MAX) begin
              r_state  <= ST_RUN;
              r_addr_a <= w_addr_a;
              r_addr_b <= w_addr_b;
              r_tw     <= w_tw;
              r_stage  <= w_sel_s;
              r_last   <= w_last;
            end else begin
              r_i      <= w_i_nxt;
              r_addr_a <= w_i_nxt;
              r_addr_b <= w_i_rev;
            end
          end
        end
`endif
        ST_RUN: begin
          if (w_xfer) begin
            if (w_b_wrap && w_s_last) begin
              r_state     <= ST_FIN;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_last      <= 1'b0;
              r_s         <= '0;
              r_b         <= '0;
            end else begin
              r_s      <= w_nxt_s;
              r_b      <= w_nxt_b;
              r_addr_a <= w_addr_a;
              r_addr_b <= w_addr_b;
              r_tw     <= w_tw;
              r_stage  <= w_sel_s;
              r_last   <= w_last;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign addr_a    = r_addr_a;
  assign addr_b    = r_addr_b;
  assign tw_idx    = r_tw;
  assign stage     = r_stage;
  assign last      = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Directed bench for fft_addr_sequencer. Two instances share clock and reset:
// u_dut3 (LOG2N=3) for the hand-checked sequences and u_dut8 (LOG2N=8) for the
// long walk with random back-pressure. Words are packed as
// {last, stage[3:0], tw[10:0], addr_b[11:0], addr_a[11:0]}.
module tb_fft_addr_sequencer;
  localparam int W = 40;
`ifdef FFT_BITREV_LOAD_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  logic       start3, ready3, valid3, last3, busy3, done3;
  logic [2:0] a3, b3;
  logic [1:0] tw3;
  logic [3:0] st3;
  logic       start8, ready8, valid8, last8, busy8, done8;
  logic [7:0] a8, b8;
  logic [6:0] tw8;
  logic [3:0] st8;

  logic [W-1:0] obs3, obs8;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign obs3 = {last3, st3, 9'b0, tw3, 9'b0, b3, 9'b0, a3};
  assign obs8 = {last8, st8, 4'b0, tw8, 4'b0, b8, 4'b0, a8};

  fft_addr_sequencer #(.LOG2N(3), .STAGE_W(4)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .out_ready(ready3),
    .out_valid(valid3), .addr_a(a3), .addr_b(b3), .tw_idx(tw3),
    .stage(st3), .last(last3), .busy(busy3), .done(done3));

  fft_addr_sequencer #(.LOG2N(8), .STAGE_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .out_ready(ready8),
    .out_valid(valid8), .addr_a(a8), .addr_b(b8), .tw_idx(tw8),
    .stage(st8), .last(last8), .busy(busy8), .done(done8));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int a, input int b, input int tw, input int st, input int lst);
    logic [W-1:0] p;
    p = {lst[0], st[3:0], tw[10:0], b[11:0], a[11:0]};
    return p;
  endfunction

  function automatic int brev(input int x, input int l);
    int r;
    r = 0;
    for (int k = 0; k < l; k++) if (x[k]) r = r | (1 << (l - 1 - k));
    return r;
  endfunction

  // reference model: group-major, position-minor walk of each stage
  task automatic build_exp(input int l);
    int n, half, ngrp, a;
    n = 1 << l;
    exp_q.delete();
    if (BR) for (int i = 0; i < n; i++) exp_q.push_back(pk(i, brev(i, l), 0, 15, 0));
    for (int s = 0; s < l; s++) begin
      half = 1 << s;
      ngrp = n / (2 * half);
      for (int g = 0; g < ngrp; g++) begin
        for (int p = 0; p < half; p++) begin
          a = g * 2 * half + p;
          exp_q.push_back(pk(a, a + half, p * ngrp, s,
                             ((s == l - 1) && (g == ngrp - 1) && (p == half - 1)) ? 1 : 0));
        end
      end
    end
  endtask

  task automatic set_in(input int dut, input logic st, input logic rd);
    if (dut == 3) begin start3 = st; ready3 = rd; end
    else begin start8 = st; ready8 = rd; end
  endtask

  // mode 0: ready always high; 1: 3-cycle stall at RUN word 4;
  // 2: random ready; 3: extra start pulse at word 2
  task automatic run_xfer(input int dut, input int mode, output int nwords, output int ndone);
    int l, off, nexp, cyc, stall, done_cyc, idx;
    logic v, d, bz, rd, st, just_last, pulsed;
    logic [W-1:0] obs, e;
    int brv[8];
    brv = '{0, 4, 2, 6, 1, 5, 3, 7};
    l = (dut == 3) ? 3 : 8;
    off = BR ? (1 << l) : 0;
    nexp = l * (1 << (l - 1)) + off;
    build_exp(l);
    nwords = 0; ndone = 0; cyc = 0; stall = 0; done_cyc = -1;
    just_last = 1'b0; pulsed = 1'b0;
    set_in(dut, 1'b1, 1'b1);
    tick();
    while (cyc < 5000) begin
      if (dut == 3) begin v = valid3; obs = obs3; d = done3; bz = busy3; end
      else begin v = valid8; obs = obs8; d = done8; bz = busy8; end
      rd = 1'b1;
      st = 1'b0;
      if (mode == 1 && nwords == off + 4 && stall < 3) begin rd = 1'b0; stall++; end
      if (mode == 2) rd = ($urandom_range(0, 3) != 0);
      if (mode == 3 && nwords == 2 && !pulsed) begin st = 1'b1; pulsed = 1'b1; end
      set_in(dut, st, rd);
      if (just_last) begin
        chk("done_after_last", W'(d), W'(1));
        chk("busy_after_last", W'(bz), W'(0));
        chk("valid_in_fin", W'(v), W'(0));
        just_last = 1'b0;
      end
      if (d) begin
        if (ndone == 0) begin
          done_cyc = cyc;
          if (mode == 0) chk("done_latency", W'(cyc), W'(nexp));
        end
        ndone++;
      end
      if (!v) chk("last_unqualified", W'(obs[W-1]), W'(0));
      if (mode == 1 && !rd) chk("stall_hold", {obs[W-2:0], v}, {pk(0, 2, 0, 1, 0), 1'b1} >> 0);
      if (v && rd) begin
        idx = nwords - off;
        if (exp_q.size() == 0) chk("extra_word", obs, '1);
        else begin
          e = exp_q.pop_front();
          chk("scoreboard", obs, e);
        end
        if (BR && dut == 3 && nwords < 8) chk("load_addr_b", W'(obs[23:12]), W'(brv[nwords]));
        if (dut == 3 && idx == 0)  chk("w0", obs, pk(0, 1, 0, 0, 0));
        if (dut == 3 && idx == 5)  chk("w5", obs, pk(1, 3, 2, 1, 0));
        if (dut == 3 && idx == 11) chk("w11", obs, pk(3, 7, 3, 2, 1));
        if (dut == 8 && idx == 0)  chk("w8_0", obs, pk(0, 1, 0, 0, 0));
        if (dut == 8 && idx == 1023) chk("w8_1023", obs, pk(127, 255, 127, 7, 1));
        if (nwords == nexp - 1) just_last = 1'b1;
        nwords++;
      end
      tick();
      cyc++;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    set_in(dut, 1'b0, 1'b0);
    if (done_cyc < 0) chk("timeout_no_done", W'(0), W'(1));
    chk("word_count", W'(nwords), W'(nexp));
    chk("done_count", W'(ndone), W'(1));
    chk("busy_idle", W'(dut == 3 ? busy3 : busy8), W'(0));
  endtask

  initial begin
    int nw, nd;
    reset = 1'b1;
    start3 = 1'b0; ready3 = 1'b0; start8 = 1'b0; ready8 = 1'b0;
    tick();
    tick();
    chk("rst_out3", {obs3, valid3, busy3, done3} >> 0, '0);
    reset = 1'b0;
    tick();
    chk("idle_out3", {obs3, valid3, busy3, done3} >> 0, '0);
    chk("idle_out8", {obs8, valid8, busy8, done8} >> 0, '0);

    // plain transform
    run_xfer(3, 0, nw, nd);
    // back-pressure at stage 1, b=0
    run_xfer(3, 1, nw, nd);
    // start while busy is ignored
    run_xfer(3, 3, nw, nd);

    // reset in the middle of a transform
    start3 = 1'b1; ready3 = 1'b1;
    tick();
    start3 = 1'b0;
    repeat (6) tick();
    chk("pre_reset_valid", W'(valid3), W'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_word", obs3, '0);
    chk("async_rst_ctl", W'({valid3, busy3, done3}), W'(0));
    tick();
    chk("rst_hold_ctl", W'({valid3, busy3, done3}), W'(0));
    reset = 1'b0;
    ready3 = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_no_done", W'({valid3, done3}), W'(0));
    end
    run_xfer(3, 0, nw, nd);

    // long walk, random back-pressure
    run_xfer(8, 2, nw, nd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
